cam_dmem_responder: RTL and testbench
=====================================

# cam_dmem_responder

Data-memory responder for the pipelined ARM core: the slave end of the core's data port (address, write data, write enable in; read data out). It combines a word-addressed data RAM with a small memory-mapped I/O window: a camera pixel FIFO, a free-running cycle counter and an LED register. Reads are combinational, so the core's memory stage gets read data in the same cycle. Writes commit on the rising clock edge.

## Interface
Parameters:
- RAM_WORDS, 256: data RAM depth in 32-bit words; power of two, 16..1024.
- FIFO_DEPTH, 16: pixel FIFO depth; power of two, 2..128.
- PIX_W, 16: camera pixel width, 1..32.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- addr  in  32  byte address from the core's ALU result; bits [1:0] are ignored.
- write_data  in  32  store data.
- write_enable  in  1  store strobe, sampled at the rising edge.
- read_data  out  32  load data; combinational from addr and the current state.
- pix_valid  in  1  camera pixel present.
- pix_data  in  PIX_W  camera pixel.
- pix_ready  out  1  equals !full; a pixel is accepted when pix_valid && pix_ready.
- led  out  8  LED register.
- overflow  out  1  sticky FIFO overflow flag.

## Operation
Address map (word-aligned):
- 0x0000..RAM_WORDS*4-1, RAM:
  - Read/write; word index is addr[log2(RAM_WORDS)+1:2].
  - Contents are not reset.
- 0x1000, CAM_DATA (R):
  - FIFO head pixel, zero-extended.
  - Reads 0 when empty.
  - Non-destructive.
- 0x1004, CAM_STATUS (R):
  - bit0 = empty, bit1 = full, bit2 = overflow.
  - bits[15:8] = count.
  - All other bits 0.
- 0x1008, CAM_CTRL (W; reads 0), write bits:
  - bit0 = pop, bit1 = clear overflow, bit2 = flush.
- 0x100C, CYCLE (R/W):
  - 32-bit counter, +1 every cycle, wraps 0xFFFFFFFF→0.
  - A write loads write_data instead of incrementing.
- 0x1010, LED (R/W): bits[7:0]; reads zero-extended.
- Any other address: reads 0, writes ignored; no state changes.

FIFO:
- Circular buffer with read and write pointers, count width log2(FIFO_DEPTH)+1.
- Push: pix_valid && !full. The pixel is written at the write pointer and the pointer wraps modulo FIFO_DEPTH.
- Pop: CAM_CTRL write with bit0 = 1 and not empty. The read pointer advances. A pop on an empty FIFO is ignored.
- Push and pop in the same cycle: both occur, count unchanged.
- Overflow: pix_valid while full. The pixel is dropped and overflow is set. A pop in the same cycle does not make room, because ready was already low.
- Flush (bit2): pointers and count go to 0. Flush wins over a simultaneous push and pop; the pushed pixel is dropped and does not set overflow.
- Clear overflow (bit1) and a new overflow event in the same cycle: set wins.
- Multiple CAM_CTRL bits in one write are all honoured, subject to the priorities above.

## Timing
- Reset (asynchronous, immediate) sets:
  - FIFO empty, count 0, pointers 0.
  - overflow 0, led 0, CYCLE 0.
  - pix_ready = 1.
  - read_data follows addr against the reset state.
- Read latency is 0 cycles. A read in the same cycle as a write returns the pre-write value; the new value is visible from the next cycle.
- Write effects (RAM, LED, CYCLE load, FIFO control) take effect at the rising edge where write_enable = 1.
- A pixel pushed at edge N is visible in CAM_DATA/CAM_STATUS after edge N.
- pix_ready deasserts in the cycle after the push that fills the FIFO. It reasserts in the cycle after the pop or flush that frees an entry.
- Reset asserted mid-operation discards FIFO contents immediately. RAM contents are preserved.

## Test plan
- RAM: write 0xDEADBEEF to 0x0004 and 0x12345678 to 0x03FC (RAM_WORDS = 256).
  - Reads return those values; 0x0008 and 0x0400 read 0 after a write to 0x0400.
  - A same-cycle read of 0x0004 during its write returns the old value.
- FIFO fill: push pixels 1..16 (FIFO_DEPTH = 16).
  - STATUS = 0x00001002 and pix_ready = 0.
  - A 17th pix_valid sets overflow: STATUS = 0x00001006.
  - CAM_DATA = 1.
- FIFO drain: pop 16 times.
  - CAM_DATA reads 1..16 in order.
  - Final STATUS = 0x00000005, since overflow stays sticky.
  - Writing CAM_CTRL = 0x2 clears it to 0x00000001.
- Same-cycle push and pop with count 3: count stays 3 and the head advances.
  - Flush with a simultaneous push gives count 0 and overflow unchanged.
  - Pop on empty: no change.
- CYCLE: write 0xFFFFFFFE at edge N.
  - Reads 0xFFFFFFFE after N, 0xFFFFFFFF after N+1, 0x00000000 after N+2.
- Async reset mid-stream, with 5 pixels queued and LED = 0xA5.
  - Asserting reset between edges immediately gives STATUS = 0x00000001, led = 0, overflow = 0, CYCLE = 0.
  - A previously written RAM word is retained.

Source files
------------

// File: rtl/cam_dmem_responder.sv
// Data-memory slave for the pipelined ARM core: word RAM plus an MMIO window
// holding a camera pixel FIFO, a free-running cycle counter and an LED register.
module cam_dmem_responder #(
  parameter int RAM_WORDS  = 256,
  parameter int FIFO_DEPTH = 16,
  parameter int PIX_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      addr,
  input  logic [31:0]      write_data,
  input  logic             write_enable,
  output logic [31:0]      read_data,
  input  logic             pix_valid,
  input  logic [PIX_W-1:0] pix_data,
  output logic             pix_ready,
  output logic [7:0]       led,
  output logic             overflow
);

  localparam int RAM_AW  = $clog2(RAM_WORDS);
  localparam int FIFO_AW = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = FIFO_AW + 1;

  // Word addresses (byte address >> 2) of the MMIO registers.
  localparam logic [29:0] W_CAM_DATA   = 30'h0000_0400;
  localparam logic [29:0] W_CAM_STATUS = 30'h0000_0401;
  localparam logic [29:0] W_CAM_CTRL   = 30'h0000_0402;
  localparam logic [29:0] W_CYCLE      = 30'h0000_0403;
  localparam logic [29:0] W_LED        = 30'h0000_0404;

  logic [31:0]        r_ram  [RAM_WORDS];
  logic [PIX_W-1:0]   r_fifo [FIFO_DEPTH];
  logic [FIFO_AW-1:0] r_wptr;
  logic [FIFO_AW-1:0] r_rptr;
  logic [CNT_W-1:0]   r_count;
  logic               r_overflow;
  logic [31:0]        r_cycle;
  logic [7:0]         r_led;

  logic [29:0]        w_word;
  logic               w_sel_ram;
  logic [RAM_AW-1:0]  w_ram_idx;
  logic               w_ctrl_we;
  logic               w_empty;
  logic               w_full;
  logic               w_flush;
  logic               w_push;
  logic               w_pop;
  logic               w_ovf_set;
  logic               w_ovf_clr;
  logic [31:0]        w_rdata;
  logic [1:0]         w_unused_bits;

  assign w_word        = addr[31:2];
  assign w_sel_ram     = (addr[31:RAM_AW+2] == '0);
  assign w_ram_idx     = addr[RAM_AW+1:2];
  assign w_unused_bits = addr[1:0];

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_ctrl_we = write_enable && (w_word == W_CAM_CTRL);

  // Flush dominates: a pixel arriving in the same cycle is dropped silently.
  assign w_flush   = w_ctrl_we && write_data[2];
  assign w_push    = pix_valid && !w_full && !w_flush;
  assign w_pop     = w_ctrl_we && write_data[0] && !w_empty && !w_flush;
  assign w_ovf_set = pix_valid && w_full;
  assign w_ovf_clr = w_ctrl_we && write_data[1];

  // Storage arrays carry no reset; RAM must survive a mid-run reset.
  always_ff @(posedge clk) begin
    if (write_enable && w_sel_ram) begin
      r_ram[w_ram_idx] <= write_data;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo[r_wptr] <= pix_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (w_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_overflow <= 1'b0;
    end else if (w_ovf_set) begin
      r_overflow <= 1'b1;
    end else if (w_ovf_clr) begin
      r_overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cycle <= '0;
    end else if (write_enable && (w_word == W_CYCLE)) begin
      r_cycle <= write_data;
    end else begin
      r_cycle <= r_cycle + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_led <= '0;
    end else if (write_enable && (w_word == W_LED)) begin
      r_led <= write_data[7:0];
    end
  end

  always_comb begin
    w_rdata = '0;
    if (w_sel_ram) begin
      w_rdata = r_ram[w_ram_idx];
    end else begin
      case (w_word)
        W_CAM_DATA:   w_rdata = w_empty ? 32'd0 : 32'(r_fifo[r_rptr]);
        W_CAM_STATUS: w_rdata = {16'd0, 8'(r_count), 5'd0, r_overflow, w_full, w_empty};
        W_CYCLE:      w_rdata = r_cycle;
        W_LED:        w_rdata = {24'd0, r_led};
        default:      w_rdata = '0;
      endcase
    end
  end

  assign read_data = w_rdata;
  assign pix_ready = !w_full;
  assign led       = r_led;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_cam_dmem_responder.sv
// Directed bench for cam_dmem_responder: RAM, pixel FIFO, CYCLE, LED and async reset.
module tb_cam_dmem_responder;

  localparam logic [31:0] A_DATA   = 32'h1000;
  localparam logic [31:0] A_STATUS = 32'h1004;
  localparam logic [31:0] A_CTRL   = 32'h1008;
  localparam logic [31:0] A_CYCLE  = 32'h100C;
  localparam logic [31:0] A_LED    = 32'h1010;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] addr = '0;
  logic [31:0] write_data = '0;
  logic        write_enable = 1'b0;
  logic [31:0] read_data;
  logic        pix_valid = 1'b0;
  logic [15:0] pix_data = '0;
  logic        pix_ready;
  logic [7:0]  led;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  cam_dmem_responder #(.RAM_WORDS(256), .FIFO_DEPTH(16), .PIX_W(16)) dut (
    .clk(clk), .reset(reset), .addr(addr), .write_data(write_data),
    .write_enable(write_enable), .read_data(read_data), .pix_valid(pix_valid),
    .pix_data(pix_data), .pix_ready(pix_ready), .led(led), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    addr = a; write_data = d; write_enable = 1'b1;
    @(posedge clk);
    #1;
    write_enable = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    addr = a;
    #1;
    d = read_data;
  endtask

  task automatic push_pix(input logic [15:0] v);
    @(negedge clk);
    pix_valid = 1'b1; pix_data = v;
    @(posedge clk);
    #1;
    pix_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    bus_read(A_STATUS, d);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL reset_status got %h exp %h", d, 32'h1); end
    bus_read(A_CYCLE, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_cycle got %h exp %h", d, 32'h0); end
    checks++; if (pix_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", pix_ready); end
    checks++; if (led !== 8'h0) begin errors++; $display("FAIL reset_led got %h exp 00", led); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", overflow); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_ram();
    logic [31:0] d;
    bus_write(32'h0000, 32'h0);
    bus_write(32'h0008, 32'h0);
    bus_write(32'h0004, 32'hDEADBEEF);
    bus_write(32'h03FC, 32'h12345678);
    bus_write(32'h0400, 32'hFFFFFFFF);
    bus_read(32'h0004, d);
    checks++; if (d !== 32'hDEADBEEF) begin errors++; $display("FAIL ram_4 got %h exp DEADBEEF", d); end
    bus_read(32'h03FC, d);
    checks++; if (d !== 32'h12345678) begin errors++; $display("FAIL ram_3fc got %h exp 12345678", d); end
    bus_read(32'h0008, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL ram_8 got %h exp 0", d); end
    bus_read(32'h0400, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL ram_400 got %h exp 0", d); end
    bus_read(32'h0000, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL ram_alias0 got %h exp 0", d); end
    bus_read(32'h0006, d);
    checks++; if (d !== 32'hDEADBEEF) begin errors++; $display("FAIL ram_lowbits got %h exp DEADBEEF", d); end
    // Same-cycle read sees the pre-write value.
    @(negedge clk);
    addr = 32'h0004; write_data = 32'h11111111; write_enable = 1'b1;
    #1;
    checks++; if (read_data !== 32'hDEADBEEF) begin errors++; $display("FAIL ram_rdw got %h exp DEADBEEF", read_data); end
    @(posedge clk);
    #1;
    write_enable = 1'b0;
    bus_read(32'h0004, d);
    checks++; if (d !== 32'h11111111) begin errors++; $display("FAIL ram_after_w got %h exp 11111111", d); end
  endtask

  task automatic test_fifo_fill_drain();
    logic [31:0] d;
    for (int i = 1; i <= 16; i++) push_pix(16'(i));
    bus_read(A_STATUS, d);
    checks++; if (d !== 32'h00001002) begin errors++; $display("FAIL fill_status got %h exp 00001002", d); end
    checks++; if (pix_ready !== 1'b0) begin errors++; $display("FAIL fill_ready got %b exp 0", pix_ready); end
    push_pix(16'hBEEF);
    bus_read(A_STATUS, d);
    checks++; if (d !== 32'h00001006) begin errors++; $display("FAIL ovf_status got %h exp 00001006", d); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_pin got %b exp 1", overflow); end
    bus_read(A_DATA, d);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL fill_head got %h exp 1", d); end
    for (int i = 1; i <= 16; i++) begin
      bus_read(A_DATA, d);
      checks++; if (d !== 32'(i)) begin errors++; $display("FAIL drain_%0d got %h exp %h", i, d, 32'(i)); end
      bus_write(A_CTRL, 32'h1);
    end
    checks++; if (pix_ready !== 1'b1) begin errors++; $display("FAIL drain_ready got %b exp 1", pix_ready); end
    bus_read(A_STATUS, d);
    checks++; if (d !== 32'h5) begin errors++; $display("FAIL drain_status got %h exp 5", d); end
    bus_write(A_CTRL, 32'h2);
    bus_read(A_STATUS, d);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL clr_ovf got %h exp 1", d); end
  endtask

  task automatic test_push_pop_flush();
    logic [31:0] d;
    push_pix(16'h21); push_pix(16'h22); push_pix(16'h23);
    @(negedge clk);
    pix_valid = 1'b1; pix_data = 16'h24;
    addr = A_CTRL; write_data = 32'h1; write_enable = 1'b1;
    @(posedge clk);
    #1;
    pix_valid = 1'b0; write_enable = 1'b0;
    bus_read(A_STATUS, d);
    checks++; if (d !== 32'h00000300) begin errors++; $display("FAIL pushpop_status got %h exp 00000300", d); end
    bus_read(A_DATA, d);
    checks++; if (d !== 32'h22) begin errors++; $display("FAIL pushpop_head got %h exp 22", d); end
    @(negedge clk);
    pix_valid = 1'b1; pix_data = 16'h55;
    addr = A_CTRL; write_data = 32'h5; write_enable = 1'b1;
    @(posedge clk);
    #1;
    pix_valid = 1'b0; write_enable = 1'b0;
    bus_read(A_STATUS, d);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL flush_status got %h exp 1", d); end
    bus_write(A_CTRL, 32'h1);
    bus_read(A_STATUS, d);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL pop_empty_status got %h exp 1", d); end
    bus_read(A_DATA, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL pop_empty_data got %h exp 0", d); end
    bus_read(A_CTRL, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL ctrl_read got %h exp 0", d); end
  endtask

  task automatic test_cycle_led();
    logic [31:0] d;
    bus_write(A_CYCLE, 32'hFFFFFFFE);
    bus_read(A_CYCLE, d);
    checks++; if (d !== 32'hFFFFFFFE) begin errors++; $display("FAIL cycle_n got %h exp FFFFFFFE", d); end
    @(posedge clk); #1;
    bus_read(A_CYCLE, d);
    checks++; if (d !== 32'hFFFFFFFF) begin errors++; $display("FAIL cycle_n1 got %h exp FFFFFFFF", d); end
    @(posedge clk); #1;
    bus_read(A_CYCLE, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL cycle_wrap got %h exp 0", d); end
    bus_write(A_LED, 32'h1A5);
    checks++; if (led !== 8'hA5) begin errors++; $display("FAIL led_pin got %h exp A5", led); end
    bus_read(A_LED, d);
    checks++; if (d !== 32'hA5) begin errors++; $display("FAIL led_read got %h exp A5", d); end
    bus_write(32'h2000, 32'hFFFFFFFF);
    bus_read(32'h2000, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL unmapped got %h exp 0", d); end
    checks++; if (led !== 8'hA5) begin errors++; $display("FAIL unmapped_led got %h exp A5", led); end
  endtask

  task automatic test_async_reset();
    logic [31:0] d;
    for (int i = 0; i < 5; i++) push_pix(16'(8'h70 + i));
    bus_read(A_STATUS, d);
    checks++; if (d !== 32'h00000500) begin errors++; $display("FAIL pre_reset_status got %h exp 00000500", d); end
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    bus_read(A_STATUS, d);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL areset_status got %h exp 1", d); end
    bus_read(A_CYCLE, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL areset_cycle got %h exp 0", d); end
    checks++; if (led !== 8'h0) begin errors++; $display("FAIL areset_led got %h exp 00", led); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL areset_ovf got %b exp 0", overflow); end
    bus_read(32'h0004, d);
    checks++; if (d !== 32'h11111111) begin errors++; $display("FAIL areset_ram got %h exp 11111111", d); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_ram();
    test_fifo_fill_drain();
    test_push_pop_flush();
    test_cycle_led();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
